// File: rtl/dispensador_pkg.sv
// Shared types and constants for the cash dispenser.
// Holds the FSM state codes, note denomination codes, the amount table
// (in Q50 units), the note-count bundle type and the default pickup timeout.
package dispensador_pkg;

  localparam int unsigned CNT_W           = 8;
  localparam int unsigned UNITS_W         = 5;
  localparam int unsigned OPC_W           = 5;
  localparam int unsigned DEN_W           = 2;
  localparam int unsigned DEFAULT_TIMEOUT = 1000;

  localparam logic [1:0] ST_REPOSO    = 2'd0;
  localparam logic [1:0] ST_CALCULO   = 2'd1;
  localparam logic [1:0] ST_ENTREGA   = 2'd2;
  localparam logic [1:0] ST_PRESENTAR = 2'd3;

  localparam logic [DEN_W-1:0] DEN_NONE = 2'b00;
  localparam logic [DEN_W-1:0] DEN_50   = 2'b01;
  localparam logic [DEN_W-1:0] DEN_100  = 2'b10;
  localparam logic [DEN_W-1:0] DEN_200  = 2'b11;

  // One count per denomination; also the layout of the reload word.
  typedef struct packed {
    logic [CNT_W-1:0] n200;
    logic [CNT_W-1:0] n100;
    logic [CNT_W-1:0] n50;
  } billetes_t;

  // Amount for a one-hot selection, in Q50 units; 0 for anything else.
  function automatic logic [UNITS_W-1:0] monto_unidades(input logic [OPC_W-1:0] opcion);
    case (opcion)
      5'b00001: return UNITS_W'(2);
      5'b00010: return UNITS_W'(4);
      5'b00100: return UNITS_W'(6);
      5'b01000: return UNITS_W'(10);
      5'b10000: return UNITS_W'(20);
      default:  return UNITS_W'(0);
    endcase
  endfunction

  // Highest denomination that still has notes pending.
  function automatic logic [DEN_W-1:0] den_mayor(input billetes_t p);
    if (p.n200 != '0)      return DEN_200;
    else if (p.n100 != '0) return DEN_100;
    else if (p.n50 != '0)  return DEN_50;
    else                   return DEN_NONE;
  endfunction

endpackage

// File: rtl/dispensador_efectivo_if.sv
// Control / mechanism / status bundle of the cash dispenser.
// master: withdrawal FSM + mechanism + customer side; slave: the dispenser.
interface dispensador_efectivo_if;
  import dispensador_pkg::*;

  logic                 efectivo;
  logic [OPC_W-1:0]     opcion;
  logic                 carga;
  billetes_t            carga_cnt;
  logic                 note_ack;
  logic                 tomado;
  logic                 note_req;
  logic [DEN_W-1:0]     note_den;
  logic                 ocupado;
  logic                 listo;
  logic                 error;
  logic                 retenido;
  logic [CNT_W-1:0]     inv_200;
  logic [CNT_W-1:0]     inv_100;
  logic [CNT_W-1:0]     inv_50;

  modport master (
    output efectivo, opcion, carga, carga_cnt, note_ack, tomado,
    input  note_req, note_den, ocupado, listo, error, retenido,
           inv_200, inv_100, inv_50
  );

  modport slave (
    input  efectivo, opcion, carga, carga_cnt, note_ack, tomado,
    output note_req, note_den, ocupado, listo, error, retenido,
           inv_200, inv_100, inv_50
  );

endinterface

// File: rtl/desglose_billetes.sv
// Greedy note split (combinational): as many Q200 as stock allows, then Q100,
// remainder in Q50. insuficiente flags a Q50 shortfall.
// Ports: unidades (amount in Q50 units), inv (stock) -> cuenta, insuficiente.
module desglose_billetes
  import dispensador_pkg::*;
(
  input  logic [UNITS_W-1:0] unidades,
  input  billetes_t          inv,
  output billetes_t          cuenta,
  output logic               insuficiente
);

  logic [CNT_W-1:0] max_200;
  logic [CNT_W-1:0] max_100;
  logic [CNT_W-1:0] rem_200;
  logic [CNT_W-1:0] rem_100;

  always_comb begin
    max_200      = CNT_W'(unidades >> 2);
    cuenta.n200  = (max_200 < inv.n200) ? max_200 : inv.n200;
    rem_200      = CNT_W'(unidades) - (cuenta.n200 << 2);
    max_100      = rem_200 >> 1;
    cuenta.n100  = (max_100 < inv.n100) ? max_100 : inv.n100;
    rem_100      = rem_200 - (cuenta.n100 << 1);
    cuenta.n50   = rem_100;
    insuficiente = (rem_100 > inv.n50);
  end

endmodule

// File: rtl/dispensador_efectivo.sv
// Cash dispenser: validates the selected amount, splits it into notes,
// feeds them one by one through the mechanism handshake and waits for the
// customer to take the cash (or retains it after TIMEOUT cycles).
// Ports: clk, rst_n (async active-low), bus (slave side of the interface:
// start/reload inputs, note handshake, status pulses, inventory counts).
module dispensador_efectivo
  import dispensador_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic                   clk,
  input logic                   rst_n,
  dispensador_efectivo_if.slave bus
);

  localparam int unsigned       TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [1:0]         state_q, state_d;
  logic [UNITS_W-1:0] amount_q, amount_d;
  billetes_t          pend_q, pend_d;
  billetes_t          inv_q, inv_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               note_req_q, note_req_d;
  logic [DEN_W-1:0]   note_den_q, note_den_d;
  logic               ocupado_q, ocupado_d;
  logic               listo_q, listo_d;
  logic               error_q, error_d;
  logic               retenido_q, retenido_d;

  billetes_t          cuenta;
  logic               insuficiente;

  desglose_billetes u_desglose (
    .unidades     (amount_q),
    .inv          (inv_q),
    .cuenta       (cuenta),
    .insuficiente (insuficiente)
  );

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REPOSO;
      amount_q   <= '0;
      pend_q     <= '0;
      inv_q      <= '0;
      timer_q    <= '0;
      note_req_q <= 1'b0;
      note_den_q <= DEN_NONE;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
      error_q    <= 1'b0;
      retenido_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      amount_q   <= amount_d;
      pend_q     <= pend_d;
      inv_q      <= inv_d;
      timer_q    <= timer_d;
      note_req_q <= note_req_d;
      note_den_q <= note_den_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
      error_q    <= error_d;
      retenido_q <= retenido_d;
    end
  end

  // Next state, datapath and next-output values.
  always_comb begin
    state_d    = state_q;
    amount_d   = amount_q;
    pend_d     = pend_q;
    inv_d      = inv_q;
    timer_d    = timer_q;
    listo_d    = 1'b0;
    error_d    = 1'b0;
    retenido_d = 1'b0;

    case (state_q)
      ST_REPOSO: begin
        // Reload has priority; a simultaneous start is dropped.
        if (bus.carga) begin
          inv_d = bus.carga_cnt;
        end else if (bus.efectivo) begin
          if ($onehot(bus.opcion)) begin
            amount_d = monto_unidades(bus.opcion);
            state_d  = ST_CALCULO;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_CALCULO: begin
        if (insuficiente) begin
          error_d = 1'b1;
          state_d = ST_REPOSO;
        end else begin
          pend_d  = cuenta;
          state_d = ST_ENTREGA;
        end
      end
      ST_ENTREGA: begin
        // The acked note is the one currently shown on note_den.
        if (note_req_q && bus.note_ack) begin
          case (note_den_q)
            DEN_200: begin
              pend_d.n200 = pend_q.n200 - CNT_W'(1);
              if (inv_q.n200 != '0) inv_d.n200 = inv_q.n200 - CNT_W'(1);
            end
            DEN_100: begin
              pend_d.n100 = pend_q.n100 - CNT_W'(1);
              if (inv_q.n100 != '0) inv_d.n100 = inv_q.n100 - CNT_W'(1);
            end
            DEN_50: begin
              pend_d.n50 = pend_q.n50 - CNT_W'(1);
              if (inv_q.n50 != '0) inv_d.n50 = inv_q.n50 - CNT_W'(1);
            end
            default: ;
          endcase
          if (pend_d == '0) begin
            timer_d = '0;
            state_d = ST_PRESENTAR;
          end
        end
      end
      ST_PRESENTAR: begin
        // tomado wins over the timeout on the same cycle.
        if (bus.tomado) begin
          listo_d = 1'b1;
          state_d = ST_REPOSO;
        end else if (timer_q == TIMER_LAST) begin
          retenido_d = 1'b1;
          state_d    = ST_REPOSO;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = ST_REPOSO;
    endcase

    note_req_d = (state_d == ST_ENTREGA);
    note_den_d = note_req_d ? den_mayor(pend_d) : DEN_NONE;
    ocupado_d  = (state_d != ST_REPOSO);
  end

  assign bus.note_req = note_req_q;
  assign bus.note_den = note_den_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.listo    = listo_q;
  assign bus.error    = error_q;
  assign bus.retenido = retenido_q;
  assign bus.inv_200  = inv_q.n200;
  assign bus.inv_100  = inv_q.n100;
  assign bus.inv_50   = inv_q.n50;

endmodule
